// File: rtl/mc_pkg.sv
// mc_pkg: FSM states, opcode/funct constants, ALU ops and the control vector shared by the multi-cycle MIPS datapath
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
  } state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_IMM, SRCB_IMM4} srcb_t;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_t;
  typedef enum logic [1:0] {WD_ALU, WD_MDR, WD_PC} wd_t;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_RTYPE = 6'h00, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    iord;
    logic    ir_we;
    logic    pc_inc;
    logic    pc_br;
    logic    pc_jmp;
    logic    ab_we;
    logic    alu_we;
    logic    srca_pc;
    srcb_t   srcb;
    alu_op_t alu_op;
    logic    mdr_we;
    logic    rf_we;
    dst_t    dst;
    wd_t     wd;
    logic    trap;
  } ctrl_t;
  function automatic alu_op_t funct_op(input logic [5:0] f);
    return f == F_SUB ? ALU_SUB : f == F_AND ? ALU_AND : f == F_OR ? ALU_OR : f == F_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  function automatic logic funct_ok(input logic [5:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  endfunction
endpackage

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main-control state machine; in clk/rst, i_op/i_funct from IR, i_ack memory ack, i_eq (A==B); out o_ctrl decoded control vector
module mc_ctrl_fsm import mc_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_ack,
  input  logic       i_eq,
  output ctrl_t      o_ctrl
);
  state_t r_state;
  state_t w_dispatch;
  always_comb
    w_dispatch = (i_op == OP_LW || i_op == OP_SW) ? MEMADR :
                 i_op == OP_RTYPE ? EXEC :
                 i_op == OP_ADDI ? ADDIEX :
                 (i_op == OP_BEQ || i_op == OP_BNE) ? BRANCH :
                 (i_op == OP_J || i_op == OP_JAL) ? JUMP : TRAP;
  always_ff @(posedge clk)
    if (rst) r_state <= FETCH;
    else case (r_state)
      FETCH:   if (i_ack) r_state <= DECODE;
      DECODE:  r_state <= w_dispatch;
      MEMADR:  r_state <= i_op == OP_LW ? MEMRD : MEMWR;
      MEMRD:   if (i_ack) r_state <= MEMWB;
      MEMWR:   if (i_ack) r_state <= FETCH;
      EXEC:    r_state <= funct_ok(i_funct) ? ALUWB : TRAP;
      ADDIEX:  r_state <= ADDIWB;
      TRAP:    r_state <= TRAP;
      default: r_state <= FETCH;
    endcase
  always_comb begin
    o_ctrl = '0;
    o_ctrl.mem_req = !rst && r_state inside {FETCH, MEMRD, MEMWR};
    o_ctrl.mem_we = !rst && r_state == MEMWR;
    o_ctrl.iord = r_state != FETCH;
    o_ctrl.ir_we = r_state == FETCH && i_ack;
    o_ctrl.pc_inc = r_state == FETCH && i_ack;
    o_ctrl.pc_br = r_state == BRANCH && (i_op == OP_BEQ ? i_eq : !i_eq);
    o_ctrl.pc_jmp = r_state == JUMP;
    o_ctrl.ab_we = r_state == DECODE;
    o_ctrl.alu_we = r_state inside {DECODE, MEMADR, EXEC, ADDIEX};
    o_ctrl.srca_pc = r_state == DECODE;
    o_ctrl.srcb = r_state == DECODE ? SRCB_IMM4 : r_state == EXEC ? SRCB_B : SRCB_IMM;
    o_ctrl.alu_op = r_state == EXEC ? funct_op(i_funct) : ALU_ADD;
    o_ctrl.mdr_we = r_state == MEMRD && i_ack;
    o_ctrl.rf_we = r_state inside {MEMWB, ALUWB, ADDIWB} || (r_state == JUMP && i_op == OP_JAL);
    o_ctrl.dst = r_state == ALUWB ? DST_RD : r_state == JUMP ? DST_RA : DST_RT;
    o_ctrl.wd = r_state == MEMWB ? WD_MDR : r_state == JUMP ? WD_PC : WD_ALU;
    o_ctrl.trap = r_state == TRAP;
  end
endmodule

// File: rtl/mc_datapath_hs.sv
// mc_datapath_hs: multi-cycle MIPS datapath with handshaked shared memory port (mem_req/we/addr/wdata out, mem_rdata/ack in), pc_dbg/instr_dbg/trap status
module mc_datapath_hs import mc_pkg::*; #(
  parameter int BUS_WIDTH = 32,
  parameter int REG_ADDR = 5,
  parameter int IMM_WIDTH = 16,
  parameter logic [BUS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [BUS_WIDTH-1:0] pc_dbg,
  output logic [BUS_WIDTH-1:0] instr_dbg,
  output logic                 trap
);
  logic [BUS_WIDTH-1:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
  logic [BUS_WIDTH-1:0] r_rf [2**REG_ADDR];
  ctrl_t w_ctrl;
  logic [BUS_WIDTH-1:0] w_imm, w_srca, w_srcb, w_alu, w_wd, w_jmp;
  logic [REG_ADDR-1:0] w_rs, w_rt, w_rd, w_wa;
  mc_ctrl_fsm u_fsm (
    .clk(clk),
    .rst(rst),
    .i_op(r_ir[31:26]),
    .i_funct(r_ir[5:0]),
    .i_ack(mem_ack),
    .i_eq(r_a == r_b),
    .o_ctrl(w_ctrl)
  );
  always_comb begin
    w_imm = {{(BUS_WIDTH-IMM_WIDTH){r_ir[IMM_WIDTH-1]}}, r_ir[IMM_WIDTH-1:0]};
    w_rs = REG_ADDR'(r_ir[25:21]);
    w_rt = REG_ADDR'(r_ir[20:16]);
    w_rd = REG_ADDR'(r_ir[15:11]);
    w_srca = w_ctrl.srca_pc ? r_pc : r_a;
    w_srcb = w_ctrl.srcb == SRCB_B ? r_b : w_ctrl.srcb == SRCB_IMM ? w_imm : w_imm << 2;
    w_alu = w_ctrl.alu_op == ALU_SUB ? w_srca - w_srcb :
            w_ctrl.alu_op == ALU_AND ? w_srca & w_srcb :
            w_ctrl.alu_op == ALU_OR ? w_srca | w_srcb :
            w_ctrl.alu_op == ALU_SLT ? BUS_WIDTH'($signed(w_srca) < $signed(w_srcb)) : w_srca + w_srcb;
    w_wa = w_ctrl.dst == DST_RD ? w_rd : w_ctrl.dst == DST_RA ? {REG_ADDR{1'b1}} : w_rt;
    w_wd = w_ctrl.wd == WD_MDR ? r_mdr : w_ctrl.wd == WD_PC ? r_pc : r_alu;
    w_jmp = {r_pc[BUS_WIDTH-1:28], r_ir[25:0], 2'b00};
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_a <= '0;
      r_b <= '0;
      r_alu <= '0;
      r_mdr <= '0;
      for (int i = 0; i < 2**REG_ADDR; i++) r_rf[i] <= '0;
    end else begin
      if (w_ctrl.ir_we) r_ir <= mem_rdata;
      if (w_ctrl.pc_inc) r_pc <= r_pc + BUS_WIDTH'(4);
      else if (w_ctrl.pc_br) r_pc <= r_alu;
      else if (w_ctrl.pc_jmp) r_pc <= w_jmp;
      if (w_ctrl.ab_we) begin
        r_a <= r_rf[w_rs];
        r_b <= r_rf[w_rt];
      end
      if (w_ctrl.alu_we) r_alu <= w_alu;
      if (w_ctrl.mdr_we) r_mdr <= mem_rdata;
      if (w_ctrl.rf_we && w_wa != '0) r_rf[w_wa] <= w_wd;
    end
  assign mem_req = w_ctrl.mem_req;
  assign mem_we = w_ctrl.mem_we;
  assign mem_addr = w_ctrl.iord ? r_alu : r_pc;
  assign mem_wdata = r_b;
  assign pc_dbg = r_pc;
  assign instr_dbg = r_ir;
  assign trap = w_ctrl.trap;
endmodule

// File: tb/tb_mc_datapath_hs.sv
// tb_mc_datapath_hs: directed self-checking bench with a wait-state memory model for mc_datapath_hs
module tb_mc_datapath_hs;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_req, mem_we, mem_ack, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg, instr_dbg;
  logic [7:0] idx;
  logic [31:0] prog [256];
  logic [31:0] dval [256];
  logic dvld [256];
  int wait_n = 0, wcnt = 0, cyc = 0, checks = 0, errors = 0;
  logic [63:0] wq [$];
  logic [31:0] fa [$];
  int ft [$];
  always #5 clk = ~clk;
  mc_datapath_hs dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .pc_dbg(pc_dbg),
    .instr_dbg(instr_dbg),
    .trap(trap)
  );
  assign idx = mem_addr[9:2];
  assign mem_ack = mem_req && wcnt >= wait_n;
  assign mem_rdata = dvld[idx] ? dval[idx] : prog[idx];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    wcnt <= (rst || !mem_req || mem_ack) ? 0 : wcnt + 1;
    if (rst) begin
      for (int i = 0; i < 256; i++) dvld[i] <= 1'b0;
      wq.delete();
      fa.delete();
      ft.delete();
    end else if (mem_req && mem_ack) begin
      if (mem_we) begin
        dval[idx] <= mem_wdata;
        dvld[idx] <= 1'b1;
        wq.push_back({mem_addr, mem_wdata});
      end else if (mem_addr == pc_dbg) begin
        fa.push_back(mem_addr);
        ft.push_back(cyc);
      end
    end
  end
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction
  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h1000FFFF;
  endtask
  task automatic release_rst();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic wait_for(input int nf, input int nw);
    int k = 0;
    while ((fa.size() < nf || wq.size() < nw) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL timeout fetches %0d need %0d writes %0d need %0d", fa.size(), nf, wq.size(), nw);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    wait_n = 0;
    clear_prog();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL reset_req got req=%b we=%b exp 0 0", mem_req, mem_we);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_fetch got req=%b we=%b addr=%h exp 1 0 00000000", mem_req, mem_we, mem_addr);
    end
    checks++;
    if (pc_dbg !== 32'h0 || instr_dbg !== 32'h0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got pc=%h ir=%h trap=%b exp 0 0 0", pc_dbg, instr_dbg, trap);
    end
  endtask
  task automatic test_wait_states();
    logic [31:0] pa = '0;
    logic pr = 1'b0, pk = 1'b0;
    int k = 0;
    rst = 1'b1;
    wait_n = 3;
    clear_prog();
    prog[0] = itype(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = itype(6'h08, 5'd1, 5'd2, 16'hFFF9);
    prog[2] = itype(6'h2B, 5'd0, 5'd1, 16'h0080);
    prog[3] = itype(6'h2B, 5'd0, 5'd2, 16'h0084);
    release_rst();
    while (fa.size() < 3 && k < 500) begin
      @(negedge clk);
      k++;
      if (pr) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== pa) begin
          errors++;
          $display("FAIL wait_stable got req=%b addr=%h exp 1 %h", mem_req, mem_addr, pa);
        end
      end
      if (pk) begin
        checks++;
        if (mem_req !== 1'b0) begin
          errors++;
          $display("FAIL req_spacing got req=%b exp 0", mem_req);
        end
      end
      pr = mem_req && !mem_ack;
      pk = mem_req && mem_ack && !mem_we;
      pa = mem_addr;
    end
    wait_for(4, 2);
    checks++;
    if (ft[1] - ft[0] !== 7 || ft[2] - ft[1] !== 7) begin
      errors++;
      $display("FAIL addi_wait_cpi got %0d %0d exp 7 7", ft[1] - ft[0], ft[2] - ft[1]);
    end
    checks++;
    if (ft[3] - ft[2] !== 10) begin
      errors++;
      $display("FAIL sw_wait_cpi got %0d exp 10", ft[3] - ft[2]);
    end
    checks++;
    if (wq[0] !== {32'h80, 32'd5}) begin
      errors++;
      $display("FAIL r1_value got %h exp %h", wq[0], {32'h80, 32'd5});
    end
    checks++;
    if (wq[1] !== {32'h84, 32'hFFFFFFFE}) begin
      errors++;
      $display("FAIL r2_value got %h exp %h", wq[1], {32'h84, 32'hFFFFFFFE});
    end
  endtask
  task automatic test_mem_round_trip();
    rst = 1'b1;
    wait_n = 0;
    clear_prog();
    prog[0] = itype(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = itype(6'h08, 5'd1, 5'd2, 16'hFFF9);
    prog[2] = itype(6'h2B, 5'd0, 5'd2, 16'h0008);
    prog[3] = itype(6'h23, 5'd0, 5'd3, 16'h0008);
    prog[4] = itype(6'h2B, 5'd0, 5'd3, 16'h0088);
    release_rst();
    wait_for(5, 2);
    checks++;
    if (wq[0] !== {32'h8, 32'hFFFFFFFE}) begin
      errors++;
      $display("FAIL sw_write got %h exp %h", wq[0], {32'h8, 32'hFFFFFFFE});
    end
    checks++;
    if (wq[1] !== {32'h88, 32'hFFFFFFFE}) begin
      errors++;
      $display("FAIL lw_r3 got %h exp %h", wq[1], {32'h88, 32'hFFFFFFFE});
    end
    checks++;
    if (ft[1] - ft[0] !== 4 || ft[3] - ft[2] !== 4) begin
      errors++;
      $display("FAIL addi_sw_cpi got %0d %0d exp 4 4", ft[1] - ft[0], ft[3] - ft[2]);
    end
    checks++;
    if (ft[4] - ft[3] !== 5) begin
      errors++;
      $display("FAIL lw_cpi got %0d exp 5", ft[4] - ft[3]);
    end
  endtask
  task automatic test_branches();
    rst = 1'b1;
    wait_n = 0;
    clear_prog();
    prog[0] = itype(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = itype(6'h05, 5'd1, 5'd2, 16'd2);
    prog[2] = itype(6'h2B, 5'd0, 5'd1, 16'h00C0);
    prog[3] = itype(6'h2B, 5'd0, 5'd1, 16'h00C4);
    prog[4] = itype(6'h04, 5'd1, 5'd1, 16'hFFFF);
    release_rst();
    wait_for(5, 0);
    checks++;
    if (fa[2] !== 32'h10 || fa[3] !== 32'h10 || fa[4] !== 32'h10) begin
      errors++;
      $display("FAIL branch_target got %h %h %h exp 10 10 10", fa[2], fa[3], fa[4]);
    end
    checks++;
    if (ft[2] - ft[1] !== 3 || ft[3] - ft[2] !== 3) begin
      errors++;
      $display("FAIL branch_cpi got %0d %0d exp 3 3", ft[2] - ft[1], ft[3] - ft[2]);
    end
    checks++;
    if (wq.size() !== 0) begin
      errors++;
      $display("FAIL skipped_stores got %0d exp 0", wq.size());
    end
  endtask
  task automatic test_jal_r0();
    logic [63:0] exp_w [7];
    exp_w = '{{32'h90, 32'h0}, {32'h94, 32'h24}, {32'hA0, 32'hFFFFFFFD}, {32'hA4, 32'h1},
              {32'hA8, 32'h1}, {32'hAC, 32'hFFFFFFFF}, {32'hB0, 32'h6}};
    rst = 1'b1;
    wait_n = 0;
    clear_prog();
    prog[0] = itype(6'h08, 5'd0, 5'd1, 16'd3);
    prog[1] = itype(6'h04, 5'd1, 5'd0, 16'd6);
    prog[2] = {6'h02, 26'h8};
    prog[8] = {6'h03, 26'h40};
    prog[64] = rtype(5'd1, 5'd1, 5'd0, 6'h20);
    prog[65] = itype(6'h2B, 5'd0, 5'd0, 16'h0090);
    prog[66] = itype(6'h2B, 5'd0, 5'd31, 16'h0094);
    prog[67] = rtype(5'd0, 5'd1, 5'd4, 6'h22);
    prog[68] = rtype(5'd4, 5'd1, 5'd5, 6'h2A);
    prog[69] = rtype(5'd4, 5'd1, 5'd6, 6'h24);
    prog[70] = rtype(5'd4, 5'd1, 5'd7, 6'h25);
    prog[71] = rtype(5'd1, 5'd1, 5'd8, 6'h20);
    for (int i = 0; i < 5; i++) prog[72 + i] = itype(6'h2B, 5'd0, 5'(4 + i), 16'(32'hA0 + 4 * i));
    release_rst();
    wait_for(6, 7);
    checks++;
    if (fa[2] !== 32'h8 || fa[3] !== 32'h20 || fa[4] !== 32'h100) begin
      errors++;
      $display("FAIL jump_path got %h %h %h exp 8 20 100", fa[2], fa[3], fa[4]);
    end
    checks++;
    if (ft[3] - ft[2] !== 3 || ft[4] - ft[3] !== 3 || ft[5] - ft[4] !== 4) begin
      errors++;
      $display("FAIL j_jal_r_cpi got %0d %0d %0d exp 3 3 4", ft[3] - ft[2], ft[4] - ft[3], ft[5] - ft[4]);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (wq[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL store_%0d got %h exp %h", i, wq[i], exp_w[i]);
      end
    end
  endtask
  task automatic test_trap();
    rst = 1'b1;
    wait_n = 0;
    clear_prog();
    prog[0] = {6'h3F, 26'h0};
    release_rst();
    repeat (4) @(negedge clk);
    repeat (5) begin
      checks++;
      if (trap !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL trapped got trap=%b req=%b exp 1 0", trap, mem_req);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (trap !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset got trap=%b req=%b exp 0 0", trap, mem_req);
    end
    prog[0] = rtype(5'd0, 5'd0, 5'd1, 6'h3F);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL refetch got req=%b addr=%h trap=%b exp 1 00000000 0", mem_req, mem_addr, trap);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (trap !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL funct_trap got trap=%b req=%b exp 1 0", trap, mem_req);
    end
  endtask
  initial begin
    test_reset();
    test_wait_states();
    test_mem_round_trip();
    test_branches();
    test_jal_r0();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_datapath_hs.md
# mc_datapath_hs

Next-generation multi-cycle MIPS core. The datapath and main-control FSM live in one block, and the bus width and register-file depth are parameters. Memory is reached through a single shared port with a request/acknowledge handshake, so any access can stall for an arbitrary number of cycles. Compared with the previous datapath, this block adds `bne`, `jal` and an illegal-opcode trap state. It sits between the unified instruction/data memory and the top-level SoC wrapper.

## Interface
Parameters:
- `BUS_WIDTH`, 32: datapath, PC and memory word width; must be ≥ 32.
- `REG_ADDR`, 5: register-file address width; the file holds 2^REG_ADDR registers.
- `IMM_WIDTH`, 16: immediate field width, sign-extended to `BUS_WIDTH`.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe; valid only while `mem_req`=1.
- `mem_addr`  out  BUS_WIDTH  byte address.
- `mem_wdata`  out  BUS_WIDTH  store data.
- `mem_rdata`  in  BUS_WIDTH  read data; valid in the cycle `mem_ack`=1.
- `mem_ack`  in  1  access complete; may arrive in the same cycle as the request.
- `pc_dbg`  out  BUS_WIDTH  current PC.
- `instr_dbg`  out  BUS_WIDTH  instruction register.
- `trap`  out  1  set on an illegal opcode; held until reset.

## Operation
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP.
- FETCH:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - On `mem_ack`: IR←`mem_rdata`, PC←PC+4, go to DECODE.
  - Without `mem_ack`: stay in FETCH with all outputs stable.
- DECODE:
  - A←rs, B←rt.
  - ALUOut←PC + (sext(imm)<<2), which is the branch target.
  - Dispatch on opcode: lw/sw→MEMADR; R-type→EXEC; addi→ADDIEX; beq/bne→BRANCH; j/jal→JUMP; anything else→TRAP.
- MEMADR: ALUOut←A+sext(imm). lw→MEMRD, sw→MEMWR.
- MEMRD: `mem_req`=1, `mem_addr`=ALUOut. On ack, MDR←`mem_rdata` and go to MEMWB.
- MEMWB: rt←MDR, then FETCH.
- MEMWR: `mem_req`=1, `mem_we`=1, `mem_addr`=ALUOut, `mem_wdata`=B. On ack go to FETCH.
- EXEC:
  - ALUOut←A op B.
  - Supported funct values: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - Any other funct goes to TRAP; otherwise go to ALUWB.
- ALUWB: rd←ALUOut, then FETCH.
- ADDIEX: ALUOut←A+sext(imm), then ADDIWB.
- ADDIWB: rt←ALUOut, then FETCH.
- BRANCH:
  - Taken when beq and A==B, or bne and A!=B.
  - If taken, PC←ALUOut. Go to FETCH either way.
- JUMP:
  - PC←{PC[BUS_WIDTH-1:28], instr[25:0], 2'b00}.
  - jal additionally writes the old PC+4 (the current PC value before the update) to register 2^REG_ADDR−1.
  - Then FETCH.
- TRAP: absorbing state with `trap`=1, `mem_req`=0. Only `rst` exits it.
- Register 0 always reads as 0; writes to it are discarded.
- Arithmetic: all operations wrap modulo 2^BUS_WIDTH, with no overflow exception.

## Timing
- Reset state: state=FETCH, PC=`RESET_PC`, IR/A/B/ALUOut/MDR=0, register file cleared, `trap`=0.
- While `rst`=1, `mem_req`=0 and `mem_we`=0.
- First request: in the first cycle after `rst` falls, `mem_req`=1 with `mem_addr`=`RESET_PC`.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are Moore outputs of registered state. They stay stable from the request cycle through the ack cycle.
- Request spacing: `mem_req` deasserts in the cycle after an ack. The only exception is MEMWR → FETCH, where back-to-back requests are legal.
- `mem_ack` is ignored in any state that has no outstanding request.
- Cycles per instruction with zero wait: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jal 3. Each wait cycle adds one.
- Reset mid-access: the request is abandoned, no register or PC update happens, and memory must tolerate the dropped request.
- `rst` and `mem_ack` in the same cycle: reset wins.

## Structure
- Package `mc_pkg` holds:
  - the `state_t` enum,
  - opcode constants (LW 0x23, SW 0x2B, RTYPE 0x00, ADDI 0x08, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03),
  - funct constants,
  - the `alu_op_t` enum.
- Sub-module `mc_ctrl_fsm` contains the state register, next-state logic and the decoded control vector.
- The top level holds the datapath registers, register file, ALU and muxes.

## Test plan
- **Reset and first fetch:** hold `rst` for 3 cycles, then release → `mem_req`=0 during reset; next cycle `mem_req`=1, `mem_addr`=0, PC=0.
- **Wait states:** program `addi $1,$0,5` then `addi $2,$1,-7`, with ack delayed 3 cycles on every access → `mem_addr`/`mem_req` are stable while waiting; $1=5, $2=0xFFFFFFFE; each instruction takes 7 cycles.
- **Memory round trip:** `sw $2,8($0)` then `lw $3,8($0)` → write at addr 8 with data 0xFFFFFFFE; $3=0xFFFFFFFE; the lw completes in 5 cycles with zero wait.
- **Branches:** `bne $1,$2,+2` (taken) then `beq $1,$1,-1` → PC=0x10 after bne; the beq loop targets PC=0x10 in 3 cycles.
- **jal and r0:** `jal 0x40` at PC=0x20, then `add $0,$1,$1` → PC=0x100, $31=0x24, $0 still reads 0.
- **Trap:** opcode 0x3F, then assert `rst` mid-trap → `trap`=1 and no requests while trapped; after reset, `trap`=0 and fetch restarts at 0.
